// File: rtl/ld_reg.sv
// ld_reg: parallel-load data register with hold and asynchronous reset.
// Captures d on a rising clk edge when ld is high, otherwise keeps its contents.
// Optional feature macro LD_REG_PARITY_EN adds a registered even-parity output
// q_par that tracks ^q and resets to ^RESET_VAL.

module ld_reg #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef LD_REG_PARITY_EN
    ,
    output logic             q_par
`endif
);

    // A zero-width register makes no sense, so stop elaboration early.
    generate
        if (WIDTH < 1) begin : g_width_check
            $error("ld_reg: WIDTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] next_q;

    // Per-bit 2:1 hold mux: take d when loading, otherwise recirculate q.
    always_comb begin
        next_q = q;
        if (ld) begin
            next_q = d;
        end
    end

    // Storage flops; reset wins over load and acts without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= next_q;
        end
    end

`ifdef LD_REG_PARITY_EN
    // Parity flop updates alongside q so it never lags the stored value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_par <= ^RESET_VAL;
        end else if (ld) begin
            q_par <= ^d;
        end
    end
`endif

    // A load must make d visible on q one edge later.
    a_load: assert property (@(posedge clk) disable iff (reset)
                             ld |=> (q == $past(d)))
        else $error("ld_reg: q did not capture d after load");

    // Without a load the contents must not move.
    a_hold: assert property (@(posedge clk) disable iff (reset)
                             !ld |=> $stable(q))
        else $error("ld_reg: q changed without load");

    // An unknown load enable at an edge means the caller is broken.
    a_ld_known: assert property (@(posedge clk) disable iff (reset)
                                 !$isunknown(ld))
        else $error("ld_reg: ld is X/Z at clock edge");

endmodule

// File: tb/tb_ld_reg.sv
// tb_ld_reg: scoreboard bench for ld_reg (WIDTH=8, RESET_VAL=0, 10 ns clock).
// Stimulus pushes expected register contents into a queue; an independent
// monitor pops and compares away from the active clock edge.

module tb_ld_reg;

    localparam int         W     = 8;
    localparam logic [7:0] RST_V = 8'h00;

    logic         clk;
    logic         reset;
    logic         ld;
    logic [W-1:0] d;
    logic [W-1:0] q;
`ifdef LD_REG_PARITY_EN
    logic         q_par;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic         par;
        string        name;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: the value the register is supposed to hold.
    logic [W-1:0] model_q;

    ld_reg #(.WIDTH(W), .RESET_VAL(RST_V)) dut (
        .clk   (clk),
        .reset (reset),
        .ld    (ld),
        .d     (d),
        .q     (q)
`ifdef LD_REG_PARITY_EN
        ,
        .q_par (q_par)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic even_par(input logic [W-1:0] v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(v[i]);
        return logic'(ones % 2);
    endfunction

    task automatic pushExpected(input string name);
        exp_t e;
        e.q    = model_q;
        e.par  = even_par(model_q);
        e.name = name;
        sb.push_back(e);
    endtask

    // One clocked cycle: drive inputs mid-low-phase, then record what q must
    // be just after the rising edge.
    task automatic applyStimulus(input logic r, input logic l,
                                 input logic [W-1:0] data, input string name);
        @(negedge clk);
        #2;
        reset = r;
        ld    = l;
        d     = data;
        if (r) model_q = RST_V;
        @(posedge clk);
        #1;
        if (!r && l) model_q = data;
        pushExpected(name);
    endtask

    // Raise reset in the low phase and expect q cleared before the next edge.
    task automatic asyncResetCheck(input string name);
        @(negedge clk);
        #1;
        reset   = 1'b1;
        model_q = RST_V;
        pushExpected(name);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (q !== e.q) begin
            errors++;
            $display("[TB] FAIL %s: q=%h expected %h at %0t", e.name, q, e.q, $time);
        end
`ifdef LD_REG_PARITY_EN
        checks++;
        if (q_par !== e.par) begin
            errors++;
            $display("[TB] FAIL %s_par: q_par=%b expected %b at %0t", e.name, q_par, e.par, $time);
        end
`endif
    endtask

    // Monitor: 4 ns after every clock transition, consume one pending entry.
    initial begin
        exp_t e;
        forever begin
            @(clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int drain;
        reset   = 1'b1;
        ld      = 1'b0;
        d       = '0;
        model_q = RST_V;

        // Power-up: reset high for a cycle, then released with ld low.
        applyStimulus(1'b1, 1'b0, 8'h00, "por_reset_high");
        applyStimulus(1'b0, 1'b0, 8'h00, "por_released");

        // Single load.
        applyStimulus(1'b0, 1'b1, 8'hF0, "load_f0");

        // Hold with changing d.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h0F, "hold_f0");

        // Asynchronous reset between edges.
        asyncResetCheck("async_reset");

        // Reset beats load, then release with load.
        applyStimulus(1'b1, 1'b1, 8'hAA, "reset_priority");
        applyStimulus(1'b0, 1'b1, 8'hAA, "release_load_aa");

        // Back-to-back loads.
        applyStimulus(1'b0, 1'b1, 8'h01, "b2b_01");
        applyStimulus(1'b0, 1'b1, 8'h80, "b2b_80");
        applyStimulus(1'b0, 1'b1, 8'hFF, "b2b_ff");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)),
                          W'($urandom), "rand");
        end

        // Occasional async resets mixed with loads.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom_range(1, 255)), "pre_async_load");
            asyncResetCheck("rand_async_reset");
            applyStimulus(1'b0, 1'b0, W'($urandom), "post_async_hold");
        end

        // Let the monitor drain, bounded.
        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: pending=%0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
